pixel_address_generator: RTL and testbench

- Streaming raster-to-ROM address generator for the image display path; the parametrised successor of the combinational row/col converter.
- Replaces per-pixel division with replication counters, so magnification costs no dividers.
- Splits the source image across multiple ROM banks and outputs a bank select instead of taking one as input.
- Magnification is latched once per frame, so changing the switches never tears an image mid-frame.

---
 rtl/pixel_address_generator_if.sv | 25 ++
 rtl/pixel_address_generator.sv | 99 +++++++++
 tb/tb_pixel_address_generator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pixel_address_generator_if.sv
// Raster-side handshake between the display timing source and the ROM address generator.
// The master drives pixel markers and magnification; the slave returns the registered ROM address.
interface pixel_address_generator_if #(
    parameter int MAG_SEL_W = 2,
    parameter int ADDR_W    = 12,
    parameter int BANK_W    = 2
);
    logic                 pixelValid;
    logic                 frameStart;
    logic                 lineEnd;
    logic [MAG_SEL_W-1:0] magSel;
    logic [ADDR_W-1:0]    addr;
    logic [BANK_W-1:0]    bank;
    logic                 addrValid;

    modport master (
        output pixelValid, frameStart, lineEnd, magSel,
        input  addr, bank, addrValid
    );

    modport slave (
        input  pixelValid, frameStart, lineEnd, magSel,
        output addr, bank, addrValid
    );
endinterface

// File: rtl/pixel_address_generator.sv
// Streaming raster-to-ROM address generator: replication counters stand in for division,
// the source image is split across ROM banks, and magnification is latched per frame.
module pixel_address_generator #(
    parameter int IMG_W     = 128,
    parameter int IMG_H     = 128,
    parameter int BANK_ROWS = 32,
    parameter int NUM_BANKS = 4,
    parameter int MAG_SEL_W = 2,
    parameter int ADDR_W    = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pixel_address_generator_if.slave   pag
);
    localparam int COL_W    = $clog2(IMG_W + 1);
    localparam int ROW_W    = $clog2(IMG_H + 1);
    localparam int COL_LO_W = $clog2(IMG_W);
    localparam int ROW_LO_W = $clog2(BANK_ROWS);
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int STAGES   = 1;

    logic [COL_W-1:0]     src_col, col_eff, col_nxt;
    logic [ROW_W-1:0]     src_row, row_eff, row_nxt;
    logic [MAG_SEL_W-1:0] col_rep, col_rep_eff, col_rep_nxt;
    logic [MAG_SEL_W-1:0] row_rep, row_rep_eff, row_rep_nxt;
    // Magnification is held as mag-1 so it fits the select width and compares directly with the rep counters.
    logic [MAG_SEL_W-1:0] mag_m1_q, mag_m1;
    logic                 in_image;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [BANK_W-1:0]    bank_nxt;
    logic [STAGES:0]      vld_pipe;

    // frameStart overrides the running counters for this same pixel, which is always (0,0).
    always_comb begin
        mag_m1      = pag.frameStart ? pag.magSel : mag_m1_q;
        col_eff     = pag.frameStart ? '0 : src_col;
        row_eff     = pag.frameStart ? '0 : src_row;
        col_rep_eff = pag.frameStart ? '0 : col_rep;
        row_rep_eff = pag.frameStart ? '0 : row_rep;

        col_nxt     = col_eff;
        row_nxt     = row_eff;
        col_rep_nxt = col_rep_eff;
        row_rep_nxt = row_rep_eff;

        if (pag.lineEnd) begin
            col_nxt     = '0;
            col_rep_nxt = '0;
            if (!pag.frameStart) begin
                if (row_rep_eff == mag_m1) begin
                    row_rep_nxt = '0;
                    row_nxt     = (row_eff == ROW_W'(IMG_H)) ? row_eff : row_eff + ROW_W'(1);
                end else begin
                    row_rep_nxt = row_rep_eff + MAG_SEL_W'(1);
                end
            end
        end else if (col_rep_eff == mag_m1) begin
            col_rep_nxt = '0;
            col_nxt     = (col_eff == COL_W'(IMG_W)) ? col_eff : col_eff + COL_W'(1);
        end else begin
            col_rep_nxt = col_rep_eff + MAG_SEL_W'(1);
        end
    end

    // Power-of-2 geometry turns divide/modulo into a shift and a concatenation.
    always_comb begin
        in_image = (row_eff < ROW_W'(IMG_H)) && (col_eff < COL_W'(IMG_W));
        addr_nxt = ADDR_W'({row_eff[ROW_LO_W-1:0], col_eff[COL_LO_W-1:0]});
        bank_nxt = BANK_W'(row_eff >> ROW_LO_W);
    end

    assign vld_pipe[0] = pag.pixelValid && in_image;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_col            <= '0;
            src_row            <= '0;
            col_rep            <= '0;
            row_rep            <= '0;
            mag_m1_q           <= '0;
            pag.addr           <= '0;
            pag.bank           <= '0;
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (pag.pixelValid) begin
                src_col  <= col_nxt;
                src_row  <= row_nxt;
                col_rep  <= col_rep_nxt;
                row_rep  <= row_rep_nxt;
                mag_m1_q <= mag_m1;
                pag.addr <= addr_nxt;
                pag.bank <= bank_nxt;
            end
        end
    end

    assign pag.addrValid = vld_pipe[STAGES];
endmodule

// File: tb/tb_pixel_address_generator.sv
// Bench for pixel_address_generator: constant vector table, directed raster sequences and
// random traffic checked against a display-coordinate / magnification reference model.
module tb_pixel_address_generator;
    localparam int IMG_W = 128, IMG_H = 128, BANK_ROWS = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_address_generator_if #(.MAG_SEL_W(2), .ADDR_W(12), .BANK_W(2)) pag ();

    pixel_address_generator #(
        .IMG_W(128), .IMG_H(128), .BANK_ROWS(32), .NUM_BANKS(4), .MAG_SEL_W(2), .ADDR_W(12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pag   (pag.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: display position within the frame; source pixel = display / mag.
    int m_mag, m_drow, m_dcol;
    bit e_valid, e_known;
    int e_addr, e_bank;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mag = 1; m_drow = 0; m_dcol = 0;
        e_valid = 0; e_known = 1; e_addr = 0; e_bank = 0;
    endtask

    task automatic step(input bit v, input bit fs, input bit le, input logic [1:0] ms);
        int r, c;
        pag.pixelValid = v;
        pag.frameStart = fs;
        pag.lineEnd    = le;
        pag.magSel     = ms;
        if (v) begin
            if (fs) begin
                m_mag = int'(ms) + 1; m_drow = 0; m_dcol = 0;
            end
            r = m_drow / m_mag;
            c = m_dcol / m_mag;
            e_valid = (r < IMG_H) && (c < IMG_W);
            e_known = e_valid;
            if (e_valid) begin
                e_addr = (r % BANK_ROWS) * IMG_W + c;
                e_bank = r / BANK_ROWS;
            end
            if (le) begin
                m_dcol = 0;
                if (!fs) m_drow++;
            end else begin
                m_dcol++;
            end
        end else begin
            e_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("addrValid", int'(pag.addrValid), int'(e_valid));
        if (e_known) begin
            chk("addr", int'(pag.addr), e_addr);
            chk("bank", int'(pag.bank), e_bank);
        end
    endtask

    task automatic do_reset();
        pag.pixelValid = 0; pag.frameStart = 0; pag.lineEnd = 0; pag.magSel = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(pag.addrValid), 0);
        chk("reset_addr", int'(pag.addr), 0);
        chk("reset_bank", int'(pag.bank), 0);
        rst_n = 1;
    endtask

    typedef struct {
        bit         v, fs, le;
        logic [1:0] ms;
        bit         ev;
        int         ea, eb;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1, 1, 0, 2'd0, 1, 0,   0};
        tbl[1]  = '{1, 0, 0, 2'd0, 1, 1,   0};
        tbl[2]  = '{0, 0, 0, 2'd0, 0, 1,   0};
        tbl[3]  = '{1, 0, 0, 2'd0, 1, 2,   0};
        tbl[4]  = '{1, 0, 1, 2'd0, 1, 3,   0};
        tbl[5]  = '{1, 0, 0, 2'd3, 1, 128, 0};
        tbl[6]  = '{1, 1, 0, 2'd1, 1, 0,   0};
        tbl[7]  = '{1, 0, 0, 2'd0, 1, 0,   0};
        tbl[8]  = '{1, 0, 0, 2'd0, 1, 1,   0};
        tbl[9]  = '{1, 0, 1, 2'd0, 1, 1,   0};
        tbl[10] = '{1, 0, 0, 2'd0, 1, 0,   0};
        tbl[11] = '{1, 0, 1, 2'd0, 1, 0,   0};
        tbl[12] = '{1, 0, 0, 2'd0, 1, 128, 0};
        tbl[13] = '{1, 1, 1, 2'd0, 1, 0,   0};
        tbl[14] = '{1, 0, 0, 2'd0, 1, 0,   0};
        tbl[15] = '{1, 0, 0, 2'd0, 1, 1,   0};

        do_reset();

        // Constant vectors: gaps, line ends, mag 2, frameStart+lineEnd together.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].fs, tbl[i].le, tbl[i].ms);
            chk($sformatf("tbl%0d_valid", i), int'(pag.addrValid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_addr", i), int'(pag.addr), tbl[i].ea);
            chk($sformatf("tbl%0d_bank", i), int'(pag.bank), tbl[i].eb);
        end

        // Full mag-1 frame; pixel 128 of line 0 has no lineEnd and falls off the right edge.
        do_reset();
        for (int ln = 0; ln < IMG_H; ln++) begin
            int npix;
            npix = (ln == 0) ? 130 : IMG_W;
            for (int px = 0; px < npix; px++) begin
                step(1, (ln == 0 && px == 0), (px == npix - 1), 2'd0);
                if (ln == 0 && px == 128) chk("col128_invalid", int'(pag.addrValid), 0);
                if (ln == 32 && px == 0) begin
                    chk("row32_bank", int'(pag.bank), 1);
                    chk("row32_addr", int'(pag.addr), 0);
                end
                if (ln == 127 && px == 127) begin
                    chk("last_bank", int'(pag.bank), 3);
                    chk("last_addr", int'(pag.addr), 4095);
                end
            end
        end
        step(1, 0, 0, 2'd0);
        chk("row128_invalid", int'(pag.addrValid), 0);

        // Mag 2: three display lines of 258 pixels; column 256 leaves the image.
        for (int ln = 0; ln < 3; ln++)
            for (int px = 0; px < 258; px++) begin
                step(1, (ln == 0 && px == 0), (px == 257), 2'd1);
                if (ln == 2 && px == 0) chk("mag2_line2", int'(pag.addr), 128);
                if (ln == 0 && px == 256) chk("mag2_col256", int'(pag.addrValid), 0);
            end

        // magSel moves to 3 mid-frame: no effect until the next frameStart, then 4x4 replication.
        for (int px = 0; px < 20; px++) step(1, (px == 0), 0, (px < 5) ? 2'd0 : 2'd3);
        chk("midframe_mag_ignored", int'(pag.addr), 19);
        for (int ln = 0; ln < 6; ln++)
            for (int px = 0; px < 24; px++) begin
                step(1, (ln == 0 && px == 0), (px == 23), 2'd3);
                if (ln == 3 && px == 7) chk("mag4_rep", int'(pag.addr), 1);
                if (ln == 4 && px == 0) chk("mag4_row1", int'(pag.addr), 128);
            end

        // Gaps inside a line.
        step(1, 1, 0, 2'd0);
        step(1, 0, 0, 2'd0);
        step(0, 0, 1, 2'd0);
        chk("gap_valid0", int'(pag.addrValid), 0);
        step(0, 1, 0, 2'd2);
        step(1, 0, 0, 2'd0);
        chk("gap_resume", int'(pag.addr), 2);

        // Asynchronous reset mid-line at source column 50 of row 1.
        step(1, 1, 0, 2'd0);
        for (int px = 1; px < IMG_W; px++) step(1, 0, (px == IMG_W - 1), 2'd0);
        for (int px = 0; px < 51; px++) step(1, 0, 0, 2'd0);
        chk("pre_rst_addr", int'(pag.addr), 128 + 50);
        #3;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_rst_addr", int'(pag.addr), 0);
        chk("async_rst_bank", int'(pag.bank), 0);
        chk("async_rst_valid", int'(pag.addrValid), 0);
        pag.pixelValid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        step(1, 0, 0, 2'd0);
        chk("post_rst_addr", int'(pag.addr), 0);
        chk("post_rst_valid", int'(pag.addrValid), 1);
        step(1, 0, 0, 2'd0);
        chk("post_rst_next", int'(pag.addr), 1);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
